// File: rtl/usb_rx_pkt_ctrl.sv
// Packet-level sequencer behind usb_rx (low-speed): validates PID, checks CRC16 on
// DATA0/DATA1, tracks the data toggle, writes packet bytes and holds a status report.
module usb_rx_pkt_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic              valid,
    input  logic [7:0]        data,
    input  logic              error,
    input  logic              toggle_clr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              pkt_done,
    input  logic              pkt_ack,
    output logic [3:0]        pkt_pid,
    output logic [ADDR_W-1:0] pkt_len,
    output logic [4:0]        pkt_status,
    output logic              toggle,
    output logic              overrun
);
    typedef enum logic [2:0] {IDLE, PID, DATA, SKIP, REPORT} state_t;

    localparam logic [ADDR_W-1:0] FULL         = ADDR_W'(MAX_LEN + 2);
    localparam logic [ADDR_W-1:0] ONE          = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO          = ADDR_W'(2);
    localparam logic [15:0]       CRC_RESIDUAL = 16'hB001;

    // Reflected CRC16 (0x8005 -> 0xA001), bytes consumed LSB first as on the wire.
    function automatic logic [15:0] crcByte(input logic [15:0] crcIn, input logic [7:0] b);
        logic [15:0] c;
        c = crcIn;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ 16'hA001;
            else             c = c >> 1;
        end
        return c;
    endfunction

    state_t            state_q, state_d;
    logic              dropPkt_q, dropPkt_d;
    logic              activePrev_q;
    logic [ADDR_W-1:0] byteCount_q, byteCount_d;
    logic [15:0]       crc_q, crc_d;
    logic [3:0]        pidReg_q, pidReg_d;
    logic              isData_q, isData_d;
    logic              rxErr_q, rxErr_d;
    logic              pidErr_q, pidErr_d;
    logic              lenErr_q, lenErr_d;
    logic              wrEn_q, wrEn_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [7:0]        wrData_q, wrData_d;
    logic              done_q, done_d;
    logic [3:0]        rptPid_q, rptPid_d;
    logic [ADDR_W-1:0] rptLen_q, rptLen_d;
    logic [4:0]        rptStatus_q, rptStatus_d;
    logic              toggle_q, toggle_d;
    logic              overrun_q, overrun_d;

    logic activeRise, ackTaken, startPkt, enterReport;
    logic shortPkt, crcErr, lenErrAll, cleanData;

    always_comb begin
        state_d     = state_q;
        dropPkt_d   = dropPkt_q;
        byteCount_d = byteCount_q;
        crc_d       = crc_q;
        pidReg_d    = pidReg_q;
        isData_d    = isData_q;
        rxErr_d     = rxErr_q;
        pidErr_d    = pidErr_q;
        lenErr_d    = lenErr_q;
        wrEn_d      = 1'b0;
        wrAddr_d    = wrAddr_q;
        wrData_d    = wrData_q;
        done_d      = done_q;
        rptPid_d    = rptPid_q;
        rptLen_d    = rptLen_q;
        rptStatus_d = rptStatus_q;
        toggle_d    = toggle_q;
        overrun_d   = overrun_q;
        startPkt    = 1'b0;
        enterReport = 1'b0;
        activeRise  = active & ~activePrev_q;
        ackTaken    = pkt_ack & done_q;

        if (ackTaken) begin
            done_d    = 1'b0;
            overrun_d = 1'b0;
        end

        unique case (state_q)
            IDLE, REPORT: begin
                if (state_q == REPORT && ackTaken && !activeRise) begin
                    state_d = IDLE;
                end else if (activeRise) begin
                    // A packet starting while a report is still unacknowledged is dropped.
                    if (done_q && !ackTaken) begin
                        state_d   = SKIP;
                        dropPkt_d = 1'b1;
                        overrun_d = 1'b1;
                    end else begin
                        state_d  = PID;
                        startPkt = 1'b1;
                    end
                end
            end
            PID: begin
                if (error) begin
                    rxErr_d   = 1'b1;
                    state_d   = SKIP;
                    dropPkt_d = 1'b0;
                end else if (valid) begin
                    pidReg_d = data[3:0];
                    pidErr_d = (data[7:4] != ~data[3:0]);
                    isData_d = (data[3:0] == 4'b0011) || (data[3:0] == 4'b1011);
                    state_d  = DATA;
                    if (!active) enterReport = 1'b1;
                end else if (!active) begin
                    pidErr_d    = 1'b1;
                    enterReport = 1'b1;
                end
            end
            DATA: begin
                if (error) begin
                    rxErr_d   = 1'b1;
                    state_d   = SKIP;
                    dropPkt_d = 1'b0;
                end else begin
                    if (valid) begin
                        crc_d = crcByte(crc_q, data);
                        if (byteCount_q == FULL) begin
                            lenErr_d = 1'b1;
                        end else begin
                            wrEn_d      = 1'b1;
                            wrAddr_d    = byteCount_q;
                            wrData_d    = data;
                            byteCount_d = byteCount_q + ONE;
                        end
                    end
                    if (!active) enterReport = 1'b1;
                end
            end
            SKIP: begin
                if (!active) begin
                    if (dropPkt_q) state_d = done_d ? REPORT : IDLE;
                    else           enterReport = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (startPkt) begin
            byteCount_d = '0;
            crc_d       = 16'hFFFF;
            pidReg_d    = '0;
            isData_d    = 1'b0;
            rxErr_d     = 1'b0;
            pidErr_d    = 1'b0;
            lenErr_d    = 1'b0;
        end

        // Truncated packets (rx_err) report only the receive error, not CRC/length.
        shortPkt  = byteCount_d < TWO;
        crcErr    = isData_d && !rxErr_d && !shortPkt && (crc_d != CRC_RESIDUAL);
        lenErrAll = lenErr_d || (isData_d && !rxErr_d && shortPkt);
        cleanData = isData_d && !rxErr_d && !pidErr_d && !crcErr && !lenErrAll;

        if (enterReport) begin
            state_d     = REPORT;
            done_d      = 1'b1;
            rptPid_d    = pidReg_d;
            rptLen_d    = isData_d ? (shortPkt ? '0 : byteCount_d - TWO) : byteCount_d;
            rptStatus_d = {lenErrAll, cleanData && (pidReg_d[3] != toggle_q), crcErr,
                           pidErr_d, rxErr_d};
            if (cleanData && (pidReg_d[3] == toggle_q)) toggle_d = ~toggle_q;
        end

        if (toggle_clr) toggle_d = 1'b0;
    end

    // A reset during a packet skips the rest of it without producing a report.
    always_ff @(posedge clk) begin
        activePrev_q <= active;
        if (reset) begin
            state_q     <= active ? SKIP : IDLE;
            dropPkt_q   <= 1'b1;
            byteCount_q <= '0;
            crc_q       <= 16'hFFFF;
            pidReg_q    <= '0;
            isData_q    <= 1'b0;
            rxErr_q     <= 1'b0;
            pidErr_q    <= 1'b0;
            lenErr_q    <= 1'b0;
            wrEn_q      <= 1'b0;
            wrAddr_q    <= '0;
            wrData_q    <= '0;
            done_q      <= 1'b0;
            rptPid_q    <= '0;
            rptLen_q    <= '0;
            rptStatus_q <= '0;
            toggle_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dropPkt_q   <= dropPkt_d;
            byteCount_q <= byteCount_d;
            crc_q       <= crc_d;
            pidReg_q    <= pidReg_d;
            isData_q    <= isData_d;
            rxErr_q     <= rxErr_d;
            pidErr_q    <= pidErr_d;
            lenErr_q    <= lenErr_d;
            wrEn_q      <= wrEn_d;
            wrAddr_q    <= wrAddr_d;
            wrData_q    <= wrData_d;
            done_q      <= done_d;
            rptPid_q    <= rptPid_d;
            rptLen_q    <= rptLen_d;
            rptStatus_q <= rptStatus_d;
            toggle_q    <= toggle_d;
            overrun_q   <= overrun_d;
        end
    end

    assign wr_en      = wrEn_q;
    assign wr_addr    = wrAddr_q;
    assign wr_data    = wrData_q;
    assign pkt_done   = done_q;
    assign pkt_pid    = rptPid_q;
    assign pkt_len    = rptLen_q;
    assign pkt_status = rptStatus_q;
    assign toggle     = toggle_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Testbench for usb_rx_pkt_ctrl: directed vector table, hand-written corner sequences,
// and randomized packets compared against a packet-level reference model.
module tb_usb_rx_pkt_ctrl;
    localparam int MAX_LEN = 8;
    localparam int ADDR_W  = 4;
    localparam int CAP     = MAX_LEN + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              active = 1'b0;
    logic              valid = 1'b0;
    logic [7:0]        data = 8'h00;
    logic              error = 1'b0;
    logic              toggle_clr = 1'b0;
    logic              pkt_ack = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              pkt_done;
    logic [3:0]        pkt_pid;
    logic [ADDR_W-1:0] pkt_len;
    logic [4:0]        pkt_status;
    logic              toggle;
    logic              overrun;

    always #5 clk = ~clk;

    usb_rx_pkt_ctrl #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .active(active), .valid(valid), .data(data),
        .error(error), .toggle_clr(toggle_clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .pkt_done(pkt_done), .pkt_ack(pkt_ack), .pkt_pid(pkt_pid),
        .pkt_len(pkt_len), .pkt_status(pkt_status), .toggle(toggle), .overrun(overrun)
    );

    typedef struct {
        logic [7:0] pidByte;
        int         payLen;
        logic [7:0] flip;
        bit         withCrc;
        int         errAt;
        logic [3:0] ePid;
        logic [3:0] eLen;
        logic [4:0] eStatus;
        bit         eToggle;
    } vec_t;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [7:0]  pktBytes[$];
    int          errAt = -1;
    bit          ackOnStart = 1'b0;
    bit          clrAtEnd = 1'b0;
    logic [11:0] wrQ[$];
    logic [11:0] expWr[$];
    logic [3:0]  expPid;
    logic [3:0]  expLen;
    logic [4:0]  expStatus;
    bit          modelToggle = 1'b0;
    vec_t        vecs[11];

    // Every buffer write the DUT makes is collected for comparison after the packet.
    always @(negedge clk) if (wr_en) wrQ.push_back({wr_addr, wr_data});

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic logic [15:0] crcStep(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    task automatic buildPacket(input logic [7:0] pidByte, input int len, input logic [7:0] flip,
                               input bit withCrc, input bit randomBytes);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        pktBytes.delete();
        pktBytes.push_back(pidByte);
        for (int i = 0; i < len; i++) begin
            b = randomBytes ? 8'($urandom) : 8'(8'h10 + i);
            c = crcStep(c, b);
            pktBytes.push_back(b);
        end
        if (withCrc) begin
            c = ~c;
            pktBytes.push_back(c[7:0]);
            pktBytes.push_back(c[15:8]);
        end
        if (len > 0) pktBytes[1] = pktBytes[1] ^ flip;
        errAt = -1;
    endtask

    // Reference model: a good data packet ends with the inverted CRC of its payload.
    function automatic void modelPacket();
        int         n, stored, last;
        bit         rxErr, pidErr, isData, lenErr, crcErr, seqErr;
        logic [7:0] pb;
        logic [3:0] pid;
        logic [15:0] c;
        pb     = pktBytes[0];
        last   = (errAt >= 0) ? errAt : pktBytes.size();
        rxErr  = (errAt >= 0);
        n      = last - 1;
        pid    = pb[3:0];
        pidErr = (pb[7:4] != ~pb[3:0]);
        isData = (pid == 4'h3) || (pid == 4'hB);
        stored = (n > CAP) ? CAP : n;
        expWr.delete();
        for (int i = 0; i < stored; i++) expWr.push_back({4'(i), pktBytes[i + 1]});
        lenErr = (n > CAP) || (isData && !rxErr && n < 2);
        crcErr = 1'b0;
        if (isData && !rxErr && n >= 2) begin
            c = 16'hFFFF;
            for (int i = 1; i <= n - 2; i++) c = crcStep(c, pktBytes[i]);
            c = ~c;
            crcErr = (pktBytes[n - 1] != c[7:0]) || (pktBytes[n] != c[15:8]);
        end
        seqErr = 1'b0;
        if (isData && !rxErr && !pidErr && !crcErr && !lenErr) begin
            if (pid[3] == modelToggle) modelToggle = ~modelToggle;
            else                       seqErr = 1'b1;
        end
        expPid    = pid;
        expLen    = isData ? ((stored >= 2) ? 4'(stored - 2) : 4'd0) : 4'(stored);
        expStatus = {lenErr, seqErr, crcErr, pidErr, rxErr};
    endfunction

    task automatic applyStimulus();
        @(negedge clk);
        active = 1'b1;
        if (ackOnStart) pkt_ack = 1'b1;
        @(negedge clk);
        pkt_ack = 1'b0;
        for (int i = 0; i < pktBytes.size(); i++) begin
            if (i == errAt) begin
                error = 1'b1;
                @(negedge clk);
                error = 1'b0;
            end
            valid = 1'b1;
            data  = pktBytes[i];
            @(negedge clk);
            valid = 1'b0;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        if (errAt == pktBytes.size()) begin
            error = 1'b1;
            @(negedge clk);
            error = 1'b0;
        end
        active = 1'b0;
        if (clrAtEnd) toggle_clr = 1'b1;
    endtask

    task automatic checkWrites(input string tag);
        checkOutput($sformatf("%s writeCount", tag), wrQ.size(), expWr.size());
        for (int i = 0; i < wrQ.size() && i < expWr.size(); i++)
            checkOutput($sformatf("%s write%0d", tag, i), wrQ[i], expWr[i]);
    endtask

    task automatic sendAndCheck(input string tag, input logic [3:0] ePid, input logic [3:0] eLen,
                                input logic [4:0] eStatus, input bit eToggle);
        wrQ.delete();
        applyStimulus();
        checkOutput($sformatf("%s doneEarly", tag), pkt_done, 0);
        @(negedge clk);
        toggle_clr = 1'b0;
        checkOutput($sformatf("%s done", tag), pkt_done, 1);
        checkOutput($sformatf("%s pid", tag), pkt_pid, ePid);
        checkOutput($sformatf("%s len", tag), pkt_len, eLen);
        checkOutput($sformatf("%s status", tag), pkt_status, eStatus);
        checkOutput($sformatf("%s toggle", tag), toggle, eToggle);
        checkOutput($sformatf("%s overrun", tag), overrun, 0);
        checkWrites(tag);
    endtask

    task automatic ackReport(input string tag);
        @(negedge clk);
        pkt_ack = 1'b1;
        @(negedge clk);
        pkt_ack = 1'b0;
        checkOutput($sformatf("%s ackDone", tag), pkt_done, 0);
        checkOutput($sformatf("%s ackOverrun", tag), overrun, 0);
    endtask

    task automatic runNormal(input string tag, input bit doAck);
        modelPacket();
        if (clrAtEnd) modelToggle = 1'b0;
        sendAndCheck(tag, expPid, expLen, expStatus, modelToggle);
        if (doAck) ackReport(tag);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] nonData[4];
        int kind, len;
        nonData = '{8'hD2, 8'h5A, 8'h1E, 8'h69};

        vecs[0]  = '{8'hC3, 8,  8'h00, 1'b1, -1, 4'h3, 4'd8, 5'b00000, 1'b1};
        vecs[1]  = '{8'hC3, 8,  8'h00, 1'b1, -1, 4'h3, 4'd8, 5'b01000, 1'b1};
        vecs[2]  = '{8'h4B, 8,  8'h00, 1'b1, -1, 4'hB, 4'd8, 5'b00000, 1'b0};
        vecs[3]  = '{8'h4B, 8,  8'h01, 1'b1, -1, 4'hB, 4'd8, 5'b00100, 1'b0};
        vecs[4]  = '{8'hC3, 0,  8'h00, 1'b1, -1, 4'h3, 4'd0, 5'b00000, 1'b1};
        vecs[5]  = '{8'hD3, 2,  8'h00, 1'b1, -1, 4'h3, 4'd2, 5'b00010, 1'b1};
        vecs[6]  = '{8'h4B, 8,  8'h00, 1'b1,  5, 4'hB, 4'd2, 5'b00001, 1'b1};
        vecs[7]  = '{8'h4B, 11, 8'h00, 1'b1, -1, 4'hB, 4'd8, 5'b10000, 1'b1};
        vecs[8]  = '{8'hD2, 0,  8'h00, 1'b0, -1, 4'h2, 4'd0, 5'b00000, 1'b1};
        vecs[9]  = '{8'h4B, 1,  8'h00, 1'b0, -1, 4'hB, 4'd0, 5'b10000, 1'b1};
        vecs[10] = '{8'h4B, 8,  8'h00, 1'b1, -1, 4'hB, 4'd8, 5'b00000, 1'b0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("resetOutputs", {wr_en, wr_addr, wr_data, pkt_done, pkt_pid, pkt_len,
                                     pkt_status, toggle, overrun}, 0);

        for (int v = 0; v < 11; v++) begin
            buildPacket(vecs[v].pidByte, vecs[v].payLen, vecs[v].flip, vecs[v].withCrc, 1'b0);
            errAt = vecs[v].errAt;
            modelPacket();
            sendAndCheck($sformatf("vec%0d", v), vecs[v].ePid, vecs[v].eLen,
                         vecs[v].eStatus, vecs[v].eToggle);
            modelToggle = vecs[v].eToggle;
            ackReport($sformatf("vec%0d", v));
        end

        // A second packet while the first report is pending is dropped and flagged.
        buildPacket(modelToggle ? 8'h4B : 8'hC3, 5, 8'h00, 1'b1, 1'b1);
        runNormal("ovrFirst", 1'b0);
        buildPacket(8'h4B, 4, 8'h00, 1'b1, 1'b1);
        wrQ.delete();
        applyStimulus();
        @(negedge clk);
        checkOutput("ovr done", pkt_done, 1);
        checkOutput("ovr flag", overrun, 1);
        checkOutput("ovr pid", pkt_pid, expPid);
        checkOutput("ovr len", pkt_len, expLen);
        checkOutput("ovr status", pkt_status, expStatus);
        checkOutput("ovr noWrites", wrQ.size(), 0);
        ackReport("ovr");

        // Ack in the same cycle as a new packet start.
        buildPacket(8'hD2, 0, 8'h00, 1'b0, 1'b0);
        runNormal("preAckRise", 1'b0);
        ackOnStart = 1'b1;
        buildPacket(modelToggle ? 8'h4B : 8'hC3, 6, 8'h00, 1'b1, 1'b1);
        runNormal("ackRise", 1'b1);
        ackOnStart = 1'b0;

        // toggle_clr wins over the flip of a good data packet.
        clrAtEnd = 1'b1;
        buildPacket(modelToggle ? 8'h4B : 8'hC3, 3, 8'h00, 1'b1, 1'b1);
        runNormal("toggleClr", 1'b1);
        clrAtEnd = 1'b0;

        // Make toggle 1, then reset mid-packet.
        buildPacket(8'hC3, 2, 8'h00, 1'b1, 1'b1);
        runNormal("preReset", 1'b1);
        wrQ.delete();
        @(negedge clk);
        active = 1'b1;
        @(negedge clk);
        valid = 1'b1;
        data  = 8'hC3;
        @(negedge clk);
        data  = 8'h10;
        @(negedge clk);
        valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            valid = 1'b1;
            data  = 8'h55;
            @(negedge clk);
        end
        valid = 1'b0;
        @(negedge clk);
        active = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("midReset done", pkt_done, 0);
        checkOutput("midReset toggle", toggle, 0);
        checkOutput("midReset overrun", overrun, 0);
        checkOutput("midReset writes", wrQ.size(), 1);
        modelToggle = 1'b0;
        buildPacket(8'hC3, 8, 8'h00, 1'b1, 1'b1);
        runNormal("postReset", 1'b1);

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 6);
            len  = $urandom_range(0, 8);
            case (kind)
                0: buildPacket(modelToggle ? 8'h4B : 8'hC3, len, 8'h00, 1'b1, 1'b1);
                1: buildPacket(($urandom_range(0, 1) == 1) ? 8'h4B : 8'hC3, len, 8'h00, 1'b1, 1'b1);
                2: buildPacket(modelToggle ? 8'h4B : 8'hC3, $urandom_range(1, 8),
                               8'(1 << $urandom_range(0, 7)), 1'b1, 1'b1);
                3: buildPacket(nonData[$urandom_range(0, 3)], $urandom_range(0, 3), 8'h00, 1'b0, 1'b1);
                4: begin
                    buildPacket(modelToggle ? 8'h4B : 8'hC3, len, 8'h00, 1'b1, 1'b1);
                    errAt = $urandom_range(1, pktBytes.size());
                end
                5: buildPacket(8'($urandom), $urandom_range(0, 12), 8'h00, 1'b0, 1'b1);
                default: buildPacket(modelToggle ? 8'h4B : 8'hC3, $urandom_range(9, 11),
                                     8'h00, 1'b1, 1'b1);
            endcase
            runNormal($sformatf("rand%0d", it), 1'b1);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
